date_counter: RTL and testbench
===============================

Name: date_counter

Overview:
- Day/month stage of the calendar chain; sits directly upstream of the year counter.
- Advances the date on the daily tick from the hour stage and uses the leap flag returned by the year counter.
- Emits the one-cycle year carry in normal mode, and the year over/under pulses during time-zone adjustment.
- Supports per-digit editing of day and month on the date screen.

Parameters:
- REPEAT_DLY, 25_000_000: hold cycles before auto-repeat starts. Used only with KEY_AUTOREPEAT_EN.
- REPEAT_PER, 5_000_000: cycles between auto-repeat steps. Used only with KEY_AUTOREPEAT_EN.

Ports:
- clk  input  1  main clock
- reset  input  1  asynchronous, active-low reset
- clk_day  input  1  one-cycle day tick from the hour stage
- leap  input  1  high when the current year is a leap year (from the year counter)
- edit_mode  input  1  high = Edit/Time-Zone mode
- screen  input  2  current screen; 1 = date screen
- edit_pos  input  3  edited digit; 0 = leftmost hex
- key_plus  input  1  active-low, debounced upstream
- key_minus  input  1  active-low, debounced upstream
- day_over_plus  input  1  time-zone carry into next day
- day_over_minus  input  1  time-zone borrow into previous day
- days  output  5  day of month, 1..31
- months  output  4  month, 1..12
- clk_year  output  1  one-cycle year carry to the year counter
- year_over_plus  output  1  one-cycle time-zone year increment
- year_over_minus  output  1  one-cycle time-zone year decrement

Behaviour:
- Reset (async, while low): days=1, months=1, all pulse outputs 0, key edge/repeat state cleared.
- maxday: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; 29 for Feb when leap=1, else 28.
- All outputs are registered. A date update is visible 1 cycle after the triggering input is sampled.
- Key step event: falling edge of key_plus/key_minus (press), sampled against the previous-cycle registered level.
- Event priority, highest first; one action per cycle:
  1. clk_day && !edit_mode: days+1; at maxday -> days=1, months+1; at Dec 31 -> Jan 1.
  2. day_over_plus && edit_mode: same carry rules as (1).
  3. day_over_minus && edit_mode: days-1; at day 1 -> previous month's maxday (Mar 1 -> Feb 28/29 using current leap); Jan 1 -> Dec 31.
  4. Plus step && edit_mode && screen==1 && edit_pos<=3: digit edit, see below.
  5. Minus step, same conditions: digit edit, see below.
- Digit edits, all cyclic within the legal range:
  - edit_pos 0: days ±10; wrap d+10>max -> d+10-max, d-10<1 -> d-10+max.
  - edit_pos 1: days ±1, wrap 1..maxday.
  - edit_pos 2: months ±10, wrap 1..12 (5+10 -> 3).
  - edit_pos 3: months ±1, wrap 1..12.
- Year pulses, each high exactly 1 cycle, coincident with the registered date change:
  - clk_year on a (1) rollover Dec 31 -> Jan 1.
  - year_over_plus on a (2) Dec 31 -> Jan 1.
  - year_over_minus on a (3) Jan 1 -> Dec 31.
- Digit edits never produce year pulses.
- Clamp: if days > maxday after a month edit or a leap change, days := maxday on the next cycle, taking precedence over events 4 and 5. Example: year edit 2020 -> 2021 with Feb 29 gives Feb 28.
- Ignored inputs:
  - clk_day while edit_mode=1 is ignored (no deferred tick).
  - day_over_* while edit_mode=0 is ignored.
  - Keys on screen!=1 or edit_pos>=4 are ignored; edge state is still tracked.
- Reset mid-pulse: the pulse is dropped; no carry is replayed after reset.

Optional Feature:
- Macro KEY_AUTOREPEAT_EN.
- Defined: holding a key low for REPEAT_DLY cycles after the press step generates an extra step. Further steps follow every REPEAT_PER cycles while the key is held. The counter clears on release or when edit conditions drop.
- Undefined: exactly one step per press; parameters unused.

Decomposition:
- Package date_pkg holds: month constants JAN..DEC; MAXDAY_31/30/29/28; function days_in_month(month, leap); edit_pos encodings POS_DAY_TENS=0, POS_DAY_UNITS=1, POS_MON_TENS=2, POS_MON_UNITS=3.
- One sub-module, key_stepper: edge detect plus optional auto-repeat, outputs a one-cycle step. Instanced once for plus and once for minus.

Test Plan:
- Normal rollover: months=12, days=31, edit_mode=0, one clk_day pulse -> next cycle days=1, months=1, clk_year high 1 cycle.
- Feb, leap=0: day 28 + clk_day -> Mar 1. Repeat with leap=1: 28 -> 29, then 29 -> Mar 1.
- Time-zone borrow: edit_mode=1, Jan 1, day_over_minus -> Dec 31, year_over_minus 1 cycle. Separately, Mar 1 with leap=1 -> Feb 29, no pulse.
- Digit edit: screen=1, edit_pos=0, month 4, day 25, press key_plus -> days=5. edit_pos=2, month 5, press plus -> months=3.
- Clamp: Feb 29 with leap=1, leap drops to 0 -> days=28 next cycle. Mar 31, edit_pos=3, minus press -> Feb, days=29/28 per leap.
- Priority/reset: clk_day and key press in the same cycle with edit_mode=0 -> only the day advance. Assert reset during a clk_year pulse -> outputs 1/1, pulse 0 immediately.
- (With KEY_AUTOREPEAT_EN) hold key_plus for REPEAT_DLY+2*REPEAT_PER cycles -> exactly 3 additional steps after the initial one (4 total).

Source files
------------

// File: rtl/date_pkg.sv
// Shared calendar constants and helpers for the day/month stage.
package date_pkg;

    localparam logic [3:0] JAN = 4'd1;
    localparam logic [3:0] FEB = 4'd2;
    localparam logic [3:0] MAR = 4'd3;
    localparam logic [3:0] APR = 4'd4;
    localparam logic [3:0] MAY = 4'd5;
    localparam logic [3:0] JUN = 4'd6;
    localparam logic [3:0] JUL = 4'd7;
    localparam logic [3:0] AUG = 4'd8;
    localparam logic [3:0] SEP = 4'd9;
    localparam logic [3:0] OCT = 4'd10;
    localparam logic [3:0] NOV = 4'd11;
    localparam logic [3:0] DEC = 4'd12;

    localparam logic [4:0] MAXDAY_31 = 5'd31;
    localparam logic [4:0] MAXDAY_30 = 5'd30;
    localparam logic [4:0] MAXDAY_29 = 5'd29;
    localparam logic [4:0] MAXDAY_28 = 5'd28;

    localparam logic [2:0] POS_DAY_TENS  = 3'd0;
    localparam logic [2:0] POS_DAY_UNITS = 3'd1;
    localparam logic [2:0] POS_MON_TENS  = 3'd2;
    localparam logic [2:0] POS_MON_UNITS = 3'd3;

    // Last legal day of a month; February depends on the leap flag.
    function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic leap);
        logic [4:0] max_day;
        case (month)
            APR, JUN, SEP, NOV: max_day = MAXDAY_30;
            FEB:                max_day = leap ? MAXDAY_29 : MAXDAY_28;
            default:            max_day = MAXDAY_31;
        endcase
        return max_day;
    endfunction

endpackage

// File: rtl/key_stepper.sv
// Converts an active-low debounced key into one-cycle step pulses.
// A step fires on the press edge. With KEY_AUTOREPEAT_EN defined, a held
// key additionally steps after REPEAT_DLY cycles and then every REPEAT_PER
// cycles; the repeat timer clears on release or when enable drops.
module key_stepper
`ifdef KEY_AUTOREPEAT_EN
#(
    parameter int unsigned REPEAT_DLY = 32'd25_000_000,
    parameter int unsigned REPEAT_PER = 32'd5_000_000
)
`endif
(
    input  logic clk,
    input  logic reset,
    input  logic i_key_n,
    input  logic i_enable,
    output logic o_step
);

    logic r_key_prev;
    logic w_press;
    logic w_repeat;

    // Previous-cycle key level for press-edge detection; released after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_key_prev <= 1'b1;
        end else begin
            r_key_prev <= i_key_n;
        end
    end

    assign w_press = r_key_prev && !i_key_n;

`ifdef KEY_AUTOREPEAT_EN
    logic        w_held;
    logic [31:0] r_cnt;
    logic        r_repeating;

    assign w_held = !r_key_prev && !i_key_n && i_enable;

    // Repeat fires at the end of the initial delay, then once per period.
    always_comb begin
        w_repeat = 1'b0;
        if (w_held) begin
            if (!r_repeating) begin
                w_repeat = (r_cnt == (REPEAT_DLY - 32'd1));
            end else begin
                w_repeat = (r_cnt == (REPEAT_PER - 32'd1));
            end
        end else begin
            w_repeat = 1'b0;
        end
    end

    // Hold-time counter; restarts whenever the key is released or editing stops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= 32'd0;
            r_repeating <= 1'b0;
        end else if (!w_held) begin
            r_cnt       <= 32'd0;
            r_repeating <= 1'b0;
        end else if (w_repeat) begin
            r_cnt       <= 32'd0;
            r_repeating <= 1'b1;
        end else begin
            r_cnt       <= r_cnt + 32'd1;
        end
    end
`else
    assign w_repeat = 1'b0;
`endif

    assign o_step = i_enable && (w_press || w_repeat);

endmodule

// File: rtl/date_counter.sv
// Day/month stage of the calendar chain. Advances on the daily tick, applies
// time-zone day carries/borrows, and supports per-digit editing of the date.
// Optional key auto-repeat is built when KEY_AUTOREPEAT_EN is defined.
module date_counter
    import date_pkg::*;
#(
    parameter int unsigned REPEAT_DLY = 32'd25_000_000,
    parameter int unsigned REPEAT_PER = 32'd5_000_000
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_day,
    input  logic       leap,
    input  logic       edit_mode,
    input  logic [1:0] screen,
    input  logic [2:0] edit_pos,
    input  logic       key_plus,
    input  logic       key_minus,
    input  logic       day_over_plus,
    input  logic       day_over_minus,
    output logic [4:0] days,
    output logic [3:0] months,
    output logic       clk_year,
    output logic       year_over_plus,
    output logic       year_over_minus
);

    logic [4:0] r_days, w_days_nxt;
    logic [3:0] r_months, w_months_nxt;
    logic       r_clk_year, r_year_plus, r_year_minus;
    logic       w_clk_year_nxt, w_year_plus_nxt, w_year_minus_nxt;
    logic       w_edit_ok, w_plus_step, w_minus_step;
    logic [4:0] w_maxday, w_prev_maxday;
    logic [3:0] w_prev_month;
    logic [5:0] w_day6, w_max6, w_sum6;
    logic       w_adv_norm, w_adv_tz, w_back_tz;

    assign w_edit_ok = edit_mode && (screen == 2'd1) && (edit_pos <= POS_MON_UNITS);

    key_stepper
`ifdef KEY_AUTOREPEAT_EN
        #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER))
`endif
        u_plus (
        .clk      (clk),
        .reset    (reset),
        .i_key_n  (key_plus),
        .i_enable (w_edit_ok),
        .o_step   (w_plus_step)
    );

    key_stepper
`ifdef KEY_AUTOREPEAT_EN
        #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER))
`endif
        u_minus (
        .clk      (clk),
        .reset    (reset),
        .i_key_n  (key_minus),
        .i_enable (w_edit_ok),
        .o_step   (w_minus_step)
    );

    assign w_maxday      = days_in_month(r_months, leap);
    assign w_prev_month  = (r_months <= JAN) ? DEC : (r_months - 4'd1);
    assign w_prev_maxday = days_in_month(w_prev_month, leap);
    assign w_day6        = {1'b0, r_days};
    assign w_max6        = {1'b0, w_maxday};
    assign w_sum6        = w_day6 + 6'd10;
    assign w_adv_norm    = clk_day && !edit_mode;
    assign w_adv_tz      = day_over_plus && edit_mode;
    assign w_back_tz     = day_over_minus && edit_mode;

    // Next date and year pulses: one action per cycle in fixed priority order.
    always_comb begin
        w_days_nxt       = r_days;
        w_months_nxt     = r_months;
        w_clk_year_nxt   = 1'b0;
        w_year_plus_nxt  = 1'b0;
        w_year_minus_nxt = 1'b0;
        if (w_adv_norm || w_adv_tz) begin
            if (r_days >= w_maxday) begin
                w_days_nxt = 5'd1;
                if (r_months >= DEC) begin
                    w_months_nxt     = JAN;
                    w_clk_year_nxt   = w_adv_norm;
                    w_year_plus_nxt  = !w_adv_norm;
                end else begin
                    w_months_nxt = r_months + 4'd1;
                end
            end else begin
                w_days_nxt = r_days + 5'd1;
            end
        end else if (w_back_tz) begin
            if (r_days <= 5'd1) begin
                w_days_nxt       = w_prev_maxday;
                w_months_nxt     = w_prev_month;
                w_year_minus_nxt = (r_months <= JAN);
            end else begin
                w_days_nxt = r_days - 5'd1;
            end
        end else if (r_days > w_maxday) begin
            // Month edit or leap change left the day out of range.
            w_days_nxt = w_maxday;
        end else if (w_plus_step || w_minus_step) begin
            // Plus wins if both keys step together.
            case (edit_pos)
                POS_DAY_TENS: begin
                    if (w_plus_step) begin
                        w_days_nxt = (w_sum6 > w_max6) ? 5'(w_sum6 - w_max6) : 5'(w_sum6);
                    end else begin
                        w_days_nxt = (w_day6 < 6'd11) ? 5'(w_day6 + w_max6 - 6'd10)
                                                      : 5'(w_day6 - 6'd10);
                    end
                end
                POS_DAY_UNITS: begin
                    if (w_plus_step) begin
                        w_days_nxt = (r_days >= w_maxday) ? 5'd1 : (r_days + 5'd1);
                    end else begin
                        w_days_nxt = (r_days <= 5'd1) ? w_maxday : (r_days - 5'd1);
                    end
                end
                POS_MON_TENS: begin
                    if (w_plus_step) begin
                        w_months_nxt = (r_months <= 4'd2) ? (r_months + 4'd10) : (r_months - 4'd2);
                    end else begin
                        w_months_nxt = (r_months <= 4'd10) ? (r_months + 4'd2) : (r_months - 4'd10);
                    end
                end
                POS_MON_UNITS: begin
                    if (w_plus_step) begin
                        w_months_nxt = (r_months >= DEC) ? JAN : (r_months + 4'd1);
                    end else begin
                        w_months_nxt = (r_months <= JAN) ? DEC : (r_months - 4'd1);
                    end
                end
                default: begin
                    w_days_nxt   = r_days;
                    w_months_nxt = r_months;
                end
            endcase
        end else begin
            w_days_nxt   = r_days;
            w_months_nxt = r_months;
        end
    end

    // Date and pulse registers; reset drops any in-flight pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_days       <= 5'd1;
            r_months     <= JAN;
            r_clk_year   <= 1'b0;
            r_year_plus  <= 1'b0;
            r_year_minus <= 1'b0;
        end else begin
            r_days       <= w_days_nxt;
            r_months     <= w_months_nxt;
            r_clk_year   <= w_clk_year_nxt;
            r_year_plus  <= w_year_plus_nxt;
            r_year_minus <= w_year_minus_nxt;
        end
    end

    assign days            = r_days;
    assign months          = r_months;
    assign clk_year        = r_clk_year;
    assign year_over_plus  = r_year_plus;
    assign year_over_minus = r_year_minus;

endmodule

// File: tb/tb_date_counter.sv
// Directed, table-driven bench for date_counter.
module tb_date_counter;

    localparam int DLY = 8;
    localparam int PER = 4;

    logic       clk = 1'b0;
    logic       reset, clk_day, leap, edit_mode;
    logic [1:0] screen;
    logic [2:0] edit_pos;
    logic       key_plus, key_minus, day_over_plus, day_over_minus;
    logic [4:0] days;
    logic [3:0] months;
    logic       clk_year, year_over_plus, year_over_minus;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    date_counter #(.REPEAT_DLY(DLY), .REPEAT_PER(PER)) dut (
        .clk             (clk),
        .reset           (reset),
        .clk_day         (clk_day),
        .leap            (leap),
        .edit_mode       (edit_mode),
        .screen          (screen),
        .edit_pos        (edit_pos),
        .key_plus        (key_plus),
        .key_minus       (key_minus),
        .day_over_plus   (day_over_plus),
        .day_over_minus  (day_over_minus),
        .days            (days),
        .months          (months),
        .clk_year        (clk_year),
        .year_over_plus  (year_over_plus),
        .year_over_minus (year_over_minus)
    );

    typedef struct {
        int sm, sd, lp;                 // preset month, day, leap
        int em, scr, pos;               // mode, screen, edit position
        int cd, dop, dom, kp, km;       // event inputs (keys: 1 = pressed)
        int xm, xd, cy, yp, ym;         // expected outputs after one cycle
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input bit plus, input int pos);
        edit_pos = 3'(pos);
        if (plus) key_plus = 1'b0; else key_minus = 1'b0;
        @(negedge clk);
        key_plus  = 1'b1;
        key_minus = 1'b1;
        @(negedge clk);
    endtask

    // Walk the DUT to a date using the edit keys (stimulus only).
    task automatic set_date(input int m, input int d, input int lp);
        leap = lp[0]; edit_mode = 1'b1; screen = 2'd1;
        clk_day = 1'b0; day_over_plus = 1'b0; day_over_minus = 1'b0;
        key_plus = 1'b1; key_minus = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 13 && int'(months) != m; i++) press(1'b1, 3);
        @(negedge clk);
        for (int i = 0; i < 32 && int'(days) != d; i++) press(1'b1, 1);
        check("preset", int'(months) * 100 + int'(days), m * 100 + d);
    endtask

    initial begin
        //          sm sd lp em scr pos cd dop dom kp km   xm xd cy yp ym
        vecs[0]  = '{12,31, 0, 0, 0, 0,  1, 0, 0, 0, 0,   1, 1, 1, 0, 0};
        vecs[1]  = '{ 2,28, 0, 0, 0, 0,  1, 0, 0, 0, 0,   3, 1, 0, 0, 0};
        vecs[2]  = '{ 2,28, 1, 0, 0, 0,  1, 0, 0, 0, 0,   2,29, 0, 0, 0};
        vecs[3]  = '{ 2,29, 1, 0, 0, 0,  1, 0, 0, 0, 0,   3, 1, 0, 0, 0};
        vecs[4]  = '{ 1, 1, 0, 1, 0, 0,  0, 0, 1, 0, 0,  12,31, 0, 0, 1};
        vecs[5]  = '{ 3, 1, 1, 1, 0, 0,  0, 0, 1, 0, 0,   2,29, 0, 0, 0};
        vecs[6]  = '{ 3, 1, 0, 1, 0, 0,  0, 0, 1, 0, 0,   2,28, 0, 0, 0};
        vecs[7]  = '{12,31, 0, 1, 0, 0,  0, 1, 0, 0, 0,   1, 1, 0, 1, 0};
        vecs[8]  = '{ 4,25, 0, 1, 1, 0,  0, 0, 0, 1, 0,   4, 5, 0, 0, 0};
        vecs[9]  = '{ 5,10, 0, 1, 1, 2,  0, 0, 0, 1, 0,   3,10, 0, 0, 0};
        vecs[10] = '{ 6,15, 0, 0, 1, 1,  1, 0, 0, 1, 0,   6,16, 0, 0, 0};
        vecs[11] = '{ 6,15, 0, 1, 0, 0,  1, 0, 0, 0, 0,   6,15, 0, 0, 0};
        vecs[12] = '{ 6,15, 0, 0, 0, 0,  0, 1, 1, 0, 0,   6,15, 0, 0, 0};
        vecs[13] = '{ 6,15, 0, 1, 0, 1,  0, 0, 0, 1, 0,   6,15, 0, 0, 0};
        vecs[14] = '{ 6,15, 0, 1, 1, 4,  0, 0, 0, 1, 0,   6,15, 0, 0, 0};
        vecs[15] = '{ 1,31, 0, 0, 0, 0,  1, 0, 0, 0, 0,   2, 1, 0, 0, 0};
        vecs[16] = '{ 4,30, 0, 0, 0, 0,  1, 0, 0, 0, 0,   5, 1, 0, 0, 0};
        vecs[17] = '{ 1, 1, 0, 1, 1, 1,  0, 0, 0, 0, 1,   1,31, 0, 0, 0};
        vecs[18] = '{12, 5, 0, 1, 1, 3,  0, 0, 0, 1, 0,   1, 5, 0, 0, 0};
        vecs[19] = '{ 4, 5, 0, 1, 1, 0,  0, 0, 0, 0, 1,   4,25, 0, 0, 0};
        vecs[20] = '{ 1,10, 0, 1, 1, 1,  0, 1, 0, 1, 0,   1,11, 0, 0, 0};
        vecs[21] = '{ 1,20, 0, 1, 1, 2,  0, 0, 0, 0, 1,   3,20, 0, 0, 0};

        reset = 1'b0; clk_day = 1'b0; leap = 1'b0; edit_mode = 1'b0;
        screen = 2'd0; edit_pos = 3'd0; key_plus = 1'b1; key_minus = 1'b1;
        day_over_plus = 1'b0; day_over_minus = 1'b0;
        #12;
        check("reset days", int'(days), 1);
        check("reset months", int'(months), 1);
        check("reset pulses", int'({clk_year, year_over_plus, year_over_minus}), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 22; i++) begin
            set_date(vecs[i].sm, vecs[i].sd, vecs[i].lp);
            edit_mode = vecs[i].em[0]; screen = 2'(vecs[i].scr); edit_pos = 3'(vecs[i].pos);
            clk_day = vecs[i].cd[0]; day_over_plus = vecs[i].dop[0]; day_over_minus = vecs[i].dom[0];
            key_plus = !vecs[i].kp[0]; key_minus = !vecs[i].km[0];
            @(negedge clk);
            clk_day = 1'b0; day_over_plus = 1'b0; day_over_minus = 1'b0;
            key_plus = 1'b1; key_minus = 1'b1;
            check($sformatf("v%0d date", i), int'(months) * 100 + int'(days), vecs[i].xm * 100 + vecs[i].xd);
            check($sformatf("v%0d pulses", i), int'({clk_year, year_over_plus, year_over_minus}),
                  vecs[i].cy * 4 + vecs[i].yp * 2 + vecs[i].ym);
            @(negedge clk);
            check($sformatf("v%0d pulses end", i), int'({clk_year, year_over_plus, year_over_minus}), 0);
            check($sformatf("v%0d date hold", i), int'(months) * 100 + int'(days), vecs[i].xm * 100 + vecs[i].xd);
        end

        // Leap drop clamps Feb 29 to Feb 28.
        set_date(2, 29, 1);
        edit_mode = 1'b0;
        leap = 1'b0;
        @(negedge clk);
        check("leap clamp", int'(months) * 100 + int'(days), 228);

        // Month edit from Mar 31 into February, then clamp per leap.
        for (int lp = 1; lp >= 0; lp--) begin
            set_date(3, 31, lp);
            edit_pos = 3'd3; key_minus = 1'b0;
            @(negedge clk);
            key_minus = 1'b1;
            check($sformatf("mon edit lp%0d", lp), int'(months) * 100 + int'(days), 231);
            @(negedge clk);
            check($sformatf("mon clamp lp%0d", lp), int'(months) * 100 + int'(days), 200 + 28 + lp);
        end

        // Reset asserted while clk_year is high.
        set_date(12, 31, 0);
        edit_mode = 1'b0; clk_day = 1'b1;
        @(negedge clk);
        clk_day = 1'b0;
        check("cy before reset", int'(clk_year), 1);
        reset = 1'b0;
        #1;
        check("reset mid date", int'(months) * 100 + int'(days), 101);
        check("reset mid cy", int'(clk_year), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("no replay cy", int'(clk_year), 0);
        check("no replay date", int'(months) * 100 + int'(days), 101);

        // Held key: one step without auto-repeat, four with it.
        set_date(1, 1, 0);
        edit_pos = 3'd1; key_plus = 1'b0;
        repeat (DLY + 2 * PER + 1) @(negedge clk);
        key_plus = 1'b1;
        @(negedge clk);
`ifdef KEY_AUTOREPEAT_EN
        check("hold steps", int'(days), 5);
`else
        check("hold steps", int'(days), 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
